// File: rtl/sfx_pkg.sv
// Shared types for the sound-effect arbiter.
//   state_t : arbiter FSM states
//   SFX_*   : sound ids (index into req[] and the note ROM)
//   note_t  : one ROM entry; half_period in clk cycles (0 = rest),
//             dur in prescaler ticks (0 = end of sound)
package sfx_pkg;

   localparam int ID_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_NEXT = 2'd3
   } state_t;

   localparam logic [ID_W-1:0] SFX_STEP  = 2'd0;
   localparam logic [ID_W-1:0] SFX_FIGHT = 2'd1;
   localparam logic [ID_W-1:0] SFX_CATCH = 2'd2;
   localparam logic [ID_W-1:0] SFX_END   = 2'd3;

   typedef struct packed {
      logic [17:0] half_period;
      logic [7:0]  dur;
   } note_t;

   function automatic note_t mk_note(input logic [17:0] hp, input logic [7:0] d);
      note_t n;
      n.half_period = hp;
      n.dur         = d;
      return n;
   endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// Note table for all sounds, registered read (data valid one cycle after addr).
//   clk, reset_n : clock, async active-low reset (clears the output register)
//   addr         : {sound id, note index}
//   note_q       : registered note entry; unlisted entries read as dur 0 (end)
module sfx_note_rom import sfx_pkg::*; #(
   parameter int IDX_W = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ID_W+IDX_W-1:0] addr,
   output note_t                 note_q
);

   logic [ID_W-1:0]  id;
   logic [IDX_W-1:0] idx;
   note_t            note_d;

   assign id  = addr[ID_W+IDX_W-1:IDX_W];
   assign idx = addr[IDX_W-1:0];

   always_comb begin
      note_d = '0;
      case (id)
         SFX_STEP: begin
            case (idx)
               IDX_W'(0): note_d = mk_note(18'd3, 8'd2);
               IDX_W'(1): note_d = mk_note(18'd0, 8'd5);
               default:   note_d = '0;
            endcase
         end
         SFX_FIGHT: begin
            case (idx)
               IDX_W'(0): note_d = mk_note(18'd2, 8'd3);
               IDX_W'(1): note_d = mk_note(18'd4, 8'd2);
               default:   note_d = '0;
            endcase
         end
         SFX_CATCH: begin
            case (idx)
               IDX_W'(0): note_d = mk_note(18'd5, 8'd2);
               default:   note_d = '0;
            endcase
         end
         default: begin
            case (idx)
               IDX_W'(0): note_d = mk_note(18'd2, 8'd1);
               IDX_W'(1): note_d = mk_note(18'd3, 8'd1);
               IDX_W'(2): note_d = mk_note(18'd1, 8'd2);
               default:   note_d = '0;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) note_q <= '0;
      else          note_q <= note_d;
   end

endmodule

// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: latches one-cycle requests, plays the highest pending
// sound from the note ROM as a square wave, pulses done on normal completion.
//   clk, reset_n : clock, async active-low reset
//   req[3:0]     : request pulses (0 step, 1 fight start, 2 catch, 3 ending jingle)
//   audio_out    : square-wave drive
//   busy         : high in every state except IDLE
//   active_id    : id being played, 0 when idle
//   done         : one-cycle pulse when a sound ends normally
// Build option: define SFX_PREEMPT_EN to let a strictly higher pending id
// abort the sound in progress (no done for the aborted sound).
//
// state | meaning
// IDLE  | nothing playing; grants highest pending id
// LOAD  | ROM entry for {id, idx} being read
// PLAY  | tone (or rest) running for dur prescaler ticks
// NEXT  | prefetched next entry checked; continue or finish with done
module sfx_arbiter import sfx_pkg::*; #(
   parameter int TICK_DIV  = 100000,
   parameter int NOTES_MAX = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [3:0]      req,
   output logic            audio_out,
   output logic            busy,
   output logic [ID_W-1:0] active_id,
   output logic            done
);

   localparam int IDX_W  = (NOTES_MAX > 1) ? $clog2(NOTES_MAX) : 1;
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NOTES_MAX - 1);
   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);

   state_t              state_q, state_d;
   logic [3:0]          pending_q, pending_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [17:0]         hp_q, hp_d;
   logic [17:0]         hp_cnt_q, hp_cnt_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [7:0]          dur_cnt_q, dur_cnt_d;
   logic                audio_q, audio_d;
   logic                done_q, done_d;

   logic [ID_W-1:0]       grant_id;
   logic                  preempt_hit;
   logic                  grant_take;
   logic [3:0]            clr_mask;
   logic [IDX_W-1:0]      idx_inc;
   logic [17:0]           hp_next;
   logic [ID_W+IDX_W-1:0] rom_addr;
   note_t                 rom_q;

   sfx_note_rom #(.IDX_W(IDX_W)) u_rom (
      .clk     (clk),
      .reset_n (reset_n),
      .addr    (rom_addr),
      .note_q  (rom_q)
   );

   always_comb begin
      if      (pending_q[3]) grant_id = SFX_END;
      else if (pending_q[2]) grant_id = SFX_CATCH;
      else if (pending_q[1]) grant_id = SFX_FIGHT;
      else                   grant_id = SFX_STEP;
   end

`ifdef SFX_PREEMPT_EN
   // grant_id is 0 with nothing pending, so the compare alone implies a pending bit
   assign preempt_hit = (state_q != ST_IDLE) && (grant_id > id_q);
`else
   assign preempt_hit = 1'b0;
`endif

   assign grant_take = ((state_q == ST_IDLE) && (pending_q != 4'b0000)) || preempt_hit;
   assign clr_mask   = grant_take ? (4'b0001 << grant_id) : 4'b0000;
   assign idx_inc    = idx_q + 1'b1;
   assign hp_next    = hp_cnt_q + 18'd1;

   // ROM is addressed one step ahead: entry 0 of the grant from IDLE, and the
   // following entry while playing so NEXT can see whether the sound continues.
   always_comb begin
      if (grant_take)              rom_addr = {grant_id, {IDX_W{1'b0}}};
      else if (state_q == ST_LOAD) rom_addr = {id_q, idx_q};
      else                         rom_addr = {id_q, idx_inc};
   end

   always_comb begin
      state_d    = state_q;
      pending_d  = (pending_q & ~clr_mask) | req;
      id_d       = id_q;
      idx_d      = idx_q;
      hp_d       = hp_q;
      hp_cnt_d   = hp_cnt_q;
      tick_cnt_d = tick_cnt_q;
      dur_cnt_d  = dur_cnt_q;
      audio_d    = 1'b0;
      done_d     = 1'b0;

      if (grant_take) begin
         state_d = ST_LOAD;
         id_d    = grant_id;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (rom_q.dur == 8'd0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = ST_PLAY;
                  hp_d       = rom_q.half_period;
                  hp_cnt_d   = '0;
                  tick_cnt_d = TICK_RELOAD;
                  dur_cnt_d  = rom_q.dur;
                  audio_d    = (rom_q.half_period != 18'd0);
               end
            end
            ST_PLAY: begin
               audio_d = audio_q;
               if (hp_q == 18'd0) begin
                  audio_d = 1'b0;
               end else if (hp_next == hp_q) begin
                  audio_d  = ~audio_q;
                  hp_cnt_d = '0;
               end else begin
                  hp_cnt_d = hp_next;
               end
               if (tick_cnt_q == '0) begin
                  tick_cnt_d = TICK_RELOAD;
                  if (dur_cnt_q == 8'd1) begin
                     state_d   = ST_NEXT;
                     dur_cnt_d = 8'd0;
                     audio_d   = 1'b0;
                  end else begin
                     dur_cnt_d = dur_cnt_q - 8'd1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q - 1'b1;
               end
            end
            ST_NEXT: begin
               if ((idx_q != IDX_LAST) && (rom_q.dur != 8'd0)) begin
                  state_d = ST_LOAD;
                  idx_d   = idx_inc;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         id_q       <= '0;
         idx_q      <= '0;
         hp_q       <= '0;
         hp_cnt_q   <= '0;
         tick_cnt_q <= '0;
         dur_cnt_q  <= '0;
         audio_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         id_q       <= id_d;
         idx_q      <= idx_d;
         hp_q       <= hp_d;
         hp_cnt_q   <= hp_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         dur_cnt_q  <= dur_cnt_d;
         audio_q    <= audio_d;
         done_q     <= done_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign active_id = busy ? id_q : '0;
   assign audio_out = audio_q;
   assign done      = done_q;

endmodule
